// File: rtl/change_dispenser.sv
// change_dispenser
//   Output-side controller for the vending FSM. Takes the one-cycle vend
//   strobe plus 2-bit change code, runs the product-release motor and the
//   coin hopper through request/acknowledge handshakes, buffers one pending
//   transaction, declares a jam on handshake timeout and counts coins paid.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   vend_in      one-cycle strobe: release product
//   change_in    change code valid with vend_in (00 none, 01..11 coins)
//   vend_done    motor finished, sampled while vend_motor is high
//   coin_ack     hopper dropped one coin, sampled while coin_req is high
//   clr_err      clears jam (and discards state) and overrun
//   vend_motor   product-release request
//   coin_req     coin-drop request
//   busy         high in any state other than IDLE and JAM
//   done         one-cycle completion pulse
//   jam          sticky jam flag
//   overrun      sticky transaction-dropped flag
//   coins_left   coins still owed for the current transaction
//   coins_total  coins dispensed since reset, wraps
module change_dispenser #(
  parameter int TIMEOUT    = 1000,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend_in,
  input  logic [1:0]       change_in,
  input  logic             vend_done,
  input  logic             coin_ack,
  input  logic             clr_err,
  output logic             vend_motor,
  output logic             coin_req,
  output logic             busy,
  output logic             done,
  output logic             jam,
  output logic             overrun,
  output logic [1:0]       coins_left,
  output logic [CNT_W-1:0] coins_total
);

  // One timer serves both the handshake timeout and the inter-coin gap.
  localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, VEND, COIN, GAP, DONE, JAM} state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic             vend_motor_q, coin_req_q, busy_q, done_q, jam_q;
  logic             overrun_q, overrun_d;
  logic [1:0]       coins_left_q;
  logic [CNT_W-1:0] coins_total_q;
  logic             pend_vld_q, pend_vend_q;
  logic [1:0]       pend_chg_q;

  logic             arrive, take_any, store, drop;
  logic             launch_vend;
  logic [1:0]       launch_chg;

  assign arrive = vend_in || (change_in != 2'b00);

  // Arrival routing. In IDLE a pending entry wins; the new arrival then
  // refills the buffer that is being emptied this same cycle.
  always_comb begin
    store       = 1'b0;
    drop        = 1'b0;
    take_any    = 1'b0;
    launch_vend = vend_in;
    launch_chg  = change_in;
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          take_any    = 1'b1;
          launch_vend = pend_vend_q;
          launch_chg  = pend_chg_q;
          store       = arrive;
        end else begin
          take_any = arrive;
        end
      end
      JAM:     drop = arrive;
      default: begin
        store = arrive && !pend_vld_q;
        drop  = arrive &&  pend_vld_q;
      end
    endcase
    // A new drop outranks a simultaneous clear.
    overrun_d = drop || (overrun_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      vend_motor_q  <= 1'b0;
      coin_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      jam_q         <= 1'b0;
      overrun_q     <= 1'b0;
      coins_left_q  <= 2'd0;
      coins_total_q <= '0;
      pend_vld_q    <= 1'b0;
      pend_vend_q   <= 1'b0;
      pend_chg_q    <= 2'd0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= overrun_d;

      if (store) begin
        pend_vld_q  <= 1'b1;
        pend_vend_q <= vend_in;
        pend_chg_q  <= change_in;
      end else if (state_q == IDLE && pend_vld_q) begin
        pend_vld_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (take_any) begin
            timer_q      <= '0;
            coins_left_q <= launch_chg;
            busy_q       <= 1'b1;
            if (launch_vend) begin
              state_q      <= VEND;
              vend_motor_q <= 1'b1;
            end else begin
              state_q    <= COIN;
              coin_req_q <= 1'b1;
            end
          end
        end
        VEND: begin
          if (vend_done) begin
            vend_motor_q <= 1'b0;
            timer_q      <= '0;
            if (coins_left_q != 2'd0) begin
              state_q    <= COIN;
              coin_req_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q      <= JAM;
            vend_motor_q <= 1'b0;
            jam_q        <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        COIN: begin
          if (coin_ack) begin
            coin_req_q    <= 1'b0;
            timer_q       <= '0;
            coins_left_q  <= coins_left_q - 2'd1;
            coins_total_q <= coins_total_q + 1'b1;
            if (coins_left_q != 2'd1) begin
              state_q <= GAP;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q    <= JAM;
            coin_req_q <= 1'b0;
            jam_q      <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        GAP: begin
          if (timer_q == TW'(GAP_CYCLES - 1)) begin
            state_q    <= COIN;
            coin_req_q <= 1'b1;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        JAM: begin
          if (clr_err) begin
            state_q      <= IDLE;
            jam_q        <= 1'b0;
            coins_left_q <= 2'd0;
            pend_vld_q   <= 1'b0;
            timer_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vend_motor  = vend_motor_q;
  assign coin_req    = coin_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign jam         = jam_q;
  assign overrun     = overrun_q;
  assign coins_left  = coins_left_q;
  assign coins_total = coins_total_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser (TIMEOUT=8, GAP_CYCLES=4).
module tb_change_dispenser;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             vend_in, vend_done, coin_ack, clr_err;
  logic [1:0]       change_in;
  logic             vend_motor, coin_req, busy, done, jam, overrun;
  logic [1:0]       coins_left;
  logic [CNT_W-1:0] coins_total;

  int n_vec = 0;
  int n_err = 0;
  int exp_total = 0;

  change_dispenser #(.TIMEOUT(8), .GAP_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .vend_in(vend_in), .change_in(change_in),
    .vend_done(vend_done), .coin_ack(coin_ack), .clr_err(clr_err),
    .vend_motor(vend_motor), .coin_req(coin_req), .busy(busy), .done(done),
    .jam(jam), .overrun(overrun), .coins_left(coins_left),
    .coins_total(coins_total)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic v, input logic [1:0] c);
    vend_in = v; change_in = c;
    step();
    vend_in = 1'b0; change_in = 2'b00;
  endtask

  // Holds coin_req for w cycles, acknowledging in the last one.
  task automatic do_coin(input int w);
    for (int i = 1; i < w; i++) step();
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
  endtask

  // Counts low cycles until coin_req rises (bounded).
  task automatic measure_gap(output int lows);
    lows = 0;
    while (!coin_req && lows < 20) begin
      lows++;
      step();
    end
  endtask

  // Handshake responder: acks each request in its second high cycle.
  task automatic serve(input int n_done, input int lim,
                       output int vends, output int coins, output int dones);
    logic pm, pc;
    pm = 1'b0; pc = 1'b0; vends = 0; coins = 0; dones = 0;
    for (int i = 0; i < lim && dones < n_done; i++) begin
      step();
      if (done) dones++;
      vend_done = vend_motor && pm;
      coin_ack  = coin_req && pc;
      if (vend_done) vends++;
      if (coin_ack) coins++;
      pm = vend_motor && !vend_done;
      pc = coin_req && !coin_ack;
    end
    vend_done = 1'b0; coin_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; vend_in = 0; change_in = 0; vend_done = 0; coin_ack = 0; clr_err = 0;
    step(); step();
    n_vec++;
    if ({vend_motor, coin_req, busy, done, jam, overrun} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got=%b want=000000", {vend_motor, coin_req, busy, done, jam, overrun});
    end
    n_vec++;
    if (coins_left !== 2'd0 || coins_total !== '0) begin
      n_err++; $display("FAIL reset_counts got left=%0d total=%0d want 0/0", coins_left, coins_total);
    end
    @(negedge clk); rst = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || coin_req !== 1'b0) begin
      n_err++; $display("FAIL reset_idle got busy=%b req=%b want 0/0", busy, coin_req);
    end
  endtask

  task automatic test_full();
    int lows;
    strobe(1'b1, 2'b11);
    n_vec++;
    if (vend_motor !== 1'b1 || coin_req !== 1'b0 || busy !== 1'b1 || coins_left !== 2'd3) begin
      n_err++; $display("FAIL full_start got mot=%b req=%b busy=%b left=%0d want 1/0/1/3", vend_motor, coin_req, busy, coins_left);
    end
    step();
    n_vec++;
    if (vend_motor !== 1'b1) begin n_err++; $display("FAIL full_mot2 got=%b want=1", vend_motor); end
    step();
    n_vec++;
    if (vend_motor !== 1'b1) begin n_err++; $display("FAIL full_mot3 got=%b want=1", vend_motor); end
    vend_done = 1'b1;
    step();
    vend_done = 1'b0;
    n_vec++;
    if (vend_motor !== 1'b0 || coin_req !== 1'b1 || coins_left !== 2'd3) begin
      n_err++; $display("FAIL full_coin1 got mot=%b req=%b left=%0d want 0/1/3", vend_motor, coin_req, coins_left);
    end
    for (int k = 0; k < 3; k++) begin
      do_coin(2);
      exp_total++;
      n_vec++;
      if (coin_req !== 1'b0 || coins_left !== 2'(2 - k) || coins_total !== CNT_W'(exp_total)) begin
        n_err++; $display("FAIL full_ack%0d got req=%b left=%0d total=%0d want 0/%0d/%0d", k, coin_req, coins_left, coins_total, 2 - k, exp_total);
      end
      if (k < 2) begin
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL full_early_done%0d got=%b want=0", k, done); end
        measure_gap(lows);
        n_vec++;
        if (lows != 4) begin n_err++; $display("FAIL full_gap%0d got=%0d want=4", k, lows); end
      end
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL full_done got done=%b busy=%b want 1/1", done, busy);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL full_after got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_coin_only();
    strobe(1'b0, 2'b01);
    n_vec++;
    if (vend_motor !== 1'b0 || coin_req !== 1'b1 || coins_left !== 2'd1) begin
      n_err++; $display("FAIL coin_only_start got mot=%b req=%b left=%0d want 0/1/1", vend_motor, coin_req, coins_left);
    end
    do_coin(2);
    exp_total++;
    n_vec++;
    if (done !== 1'b1 || coins_left !== 2'd0 || coins_total !== CNT_W'(exp_total)) begin
      n_err++; $display("FAIL coin_only_done got done=%b left=%0d total=%0d want 1/0/%0d", done, coins_left, coins_total, exp_total);
    end
    step();
  endtask

  task automatic test_reset_mid_coin();
    int lows;
    strobe(1'b0, 2'b11);
    do_coin(1);
    exp_total++;
    measure_gap(lows);
    n_vec++;
    if (coin_req !== 1'b1 || coins_left !== 2'd2 || coins_total !== CNT_W'(5)) begin
      n_err++; $display("FAIL rmid_pre got req=%b left=%0d total=%0d want 1/2/5", coin_req, coins_left, coins_total);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({vend_motor, coin_req, busy, done, jam, overrun} !== 6'b0 || coins_left !== 2'd0 || coins_total !== '0) begin
      n_err++; $display("FAIL rmid_async got flags=%b left=%0d total=%0d want 0", {vend_motor, coin_req, busy, done, jam, overrun}, coins_left, coins_total);
    end
    step();
    rst = 1'b1;
    exp_total = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || coin_req !== 1'b0 || coins_total !== '0) begin
        n_err++; $display("FAIL rmid_idle%0d got done=%b busy=%b req=%b total=%0d want 0", i, done, busy, coin_req, coins_total);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vends, coins, dones;
    strobe(1'b1, 2'b10);
    strobe(1'b1, 2'b01);
    n_vec++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_B_stored got ovr=%b want=0", overrun); end
    strobe(1'b1, 2'b00);
    n_vec++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_C_drop got ovr=%b want=1", overrun); end
    serve(2, 200, vends, coins, dones);
    exp_total += 3;
    n_vec++;
    if (dones != 2 || vends != 2 || coins != 3) begin
      n_err++; $display("FAIL b2b_counts got dones=%0d vends=%0d coins=%0d want 2/2/3", dones, vends, coins);
    end
    step(); step();
    n_vec++;
    if (busy !== 1'b0 || vend_motor !== 1'b0 || coins_total !== CNT_W'(exp_total) || overrun !== 1'b1) begin
      n_err++; $display("FAIL b2b_end got busy=%b mot=%b total=%0d ovr=%b want 0/0/%0d/1", busy, vend_motor, coins_total, overrun, exp_total);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_vec++;
    if (overrun !== 1'b0 || jam !== 1'b0) begin
      n_err++; $display("FAIL b2b_clr got ovr=%b jam=%b want 0/0", overrun, jam);
    end
  endtask

  task automatic test_timeout();
    int hi;
    strobe(1'b0, 2'b10);
    hi = coin_req ? 1 : 0;
    for (int i = 0; i < 20 && !jam; i++) begin
      step();
      if (coin_req) hi++;
    end
    n_vec++;
    if (hi != 8) begin n_err++; $display("FAIL to_req_cycles got=%0d want=8", hi); end
    n_vec++;
    if (jam !== 1'b1 || coin_req !== 1'b0 || busy !== 1'b0 || coins_left !== 2'd2) begin
      n_err++; $display("FAIL to_jam got jam=%b req=%b busy=%b left=%0d want 1/0/0/2", jam, coin_req, busy, coins_left);
    end
    strobe(1'b1, 2'b01);
    n_vec++;
    if (overrun !== 1'b1 || jam !== 1'b1 || vend_motor !== 1'b0) begin
      n_err++; $display("FAIL to_jam_drop got ovr=%b jam=%b mot=%b want 1/1/0", overrun, jam, vend_motor);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_vec++;
    if (jam !== 1'b0 || overrun !== 1'b0 || coins_left !== 2'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL to_clr got jam=%b ovr=%b left=%0d busy=%b want 0/0/0/0", jam, overrun, coins_left, busy);
    end
    step(); step();
    n_vec++;
    if (busy !== 1'b0 || coin_req !== 1'b0 || vend_motor !== 1'b0 || coins_total !== CNT_W'(exp_total)) begin
      n_err++; $display("FAIL to_idle got busy=%b req=%b mot=%b total=%0d want 0/0/0/%0d", busy, coin_req, vend_motor, coins_total, exp_total);
    end
  endtask

  task automatic test_ack_ignored();
    int lows;
    coin_ack = 1'b1;
    step(); step();
    coin_ack = 1'b0;
    n_vec++;
    if (coins_total !== CNT_W'(exp_total) || busy !== 1'b0) begin
      n_err++; $display("FAIL ign_idle got total=%0d busy=%b want %0d/0", coins_total, busy, exp_total);
    end
    strobe(1'b0, 2'b10);
    do_coin(2);
    exp_total++;
    coin_ack = 1'b1;
    step(); step();
    coin_ack = 1'b0;
    n_vec++;
    if (coins_left !== 2'd1 || coins_total !== CNT_W'(exp_total) || coin_req !== 1'b0) begin
      n_err++; $display("FAIL ign_gap got left=%0d total=%0d req=%b want 1/%0d/0", coins_left, coins_total, coin_req, exp_total);
    end
    measure_gap(lows);
    n_vec++;
    if (lows != 2) begin n_err++; $display("FAIL ign_gap_len got=%0d want=2", lows); end
    do_coin(2);
    exp_total++;
    n_vec++;
    if (done !== 1'b1 || coins_left !== 2'd0 || coins_total !== CNT_W'(exp_total)) begin
      n_err++; $display("FAIL ign_done got done=%b left=%0d total=%0d want 1/0/%0d", done, coins_left, coins_total, exp_total);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_coin_only();
    test_reset_mid_coin();
    test_back_to_back();
    test_timeout();
    test_ack_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side controller for the vending FSM.
- Consumes the FSM's one-cycle vend strobe and 2-bit change code, and drives the product-release motor and the coin hopper through request/acknowledge handshakes.
- Buffers one pending transaction, times out on jams, and keeps a running count of coins paid out.

Parameters:
- TIMEOUT, 1000: max cycles to wait for vend_done or coin_ack before declaring a jam.
- GAP_CYCLES, 4: idle cycles between consecutive coin requests, for hopper recovery; legal range 1 and up.
- CNT_W, 16: width of coins_total.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- vend_in  input  1  one-cycle strobe from the vending FSM: release product.
- change_in  input  2  one-cycle change code, valid in the same cycle as vend_in. 00 none, 01 one 5-unit coin, 10 two coins, 11 three coins.
- vend_done  input  1  motor finished, level sampled while vend_motor is high.
- coin_ack  input  1  hopper dropped one coin, sampled while coin_req is high.
- clr_err  input  1  clears jam and overrun.
- vend_motor  output  1  product-release request.
- coin_req  output  1  coin-drop request.
- busy  output  1  high in any state other than IDLE and JAM.
- done  output  1  one-cycle pulse on transaction completion.
- jam  output  1  sticky jam flag.
- overrun  output  1  sticky flag: transaction dropped.
- coins_left  output  2  coins still owed for the current transaction.
- coins_total  output  CNT_W  coins dispensed since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low, any time, asynchronous): state goes to IDLE.
  - All outputs, the pending buffer and the timers clear to 0.
  - A transaction in progress is abandoned with no done pulse.
- Transaction: the cycle where vend_in=1 or change_in!=0. A cycle with vend_in=0 and change_in=00 is ignored.
- Pending buffer, one entry {vend, change}:
  - A transaction arriving while busy, or in the same cycle the FSM leaves IDLE, is stored if the buffer is empty.
  - If the buffer is full, the transaction is dropped and overrun is set.
  - In JAM, arriving transactions are dropped and set overrun.
- States:
  - IDLE: on a new or pending transaction (pending takes priority; a new arrival then goes to the buffer), latch vend and change. coins_left is loaded with change. Go to VEND if vend=1, else to COIN.
  - VEND: vend_motor=1 and the timer counts.
    - vend_done=1: drop vend_motor at that edge; go to COIN if coins_left!=0, else DONE.
    - Timer reaches TIMEOUT: go to JAM.
  - COIN: coin_req=1 and the timer counts.
    - coin_ack=1: drop coin_req, decrement coins_left, increment coins_total. Go to GAP if coins_left is still nonzero after the decrement, else DONE.
    - Timeout: go to JAM.
    - coin_ack with coin_req low is ignored.
  - GAP: all requests low for exactly GAP_CYCLES cycles, then COIN.
  - DONE: done=1 for one cycle, then IDLE.
  - JAM: jam=1 and all requests low; coins_left holds the unpaid count.
    - clr_err=1 clears jam and overrun, zeroes coins_left, discards pending, and returns to IDLE the next cycle.
- clr_err outside JAM clears overrun only. If clr_err and a new overrun occur in the same cycle, overrun stays set.
- Timer resets to 0 on every state entry. Jam is declared when the count equals TIMEOUT with no ack seen.
- Latency: strobe at edge N gives vend_motor or coin_req high after edge N+1.
- Minimum coin period is 1 + GAP_CYCLES + ack-wait cycles.

Test Plan:
- Reset mid-COIN, with coins_total=5 and coins_left=2: rst low for 1 cycle -> all outputs 0, coins_total=0, no done pulse, IDLE.
- vend_in=1, change_in=11; vend_done after 3 cycles; coin_ack 2 cycles after each coin_req -> vend_motor high 3 cycles, three coin_req pulses each separated by 4 idle cycles, coins_left 3→2→1→0, coins_total=3, a single done pulse, busy low afterwards.
- vend_in=0, change_in=01 -> VEND skipped, one coin_req, done, coins_total=1.
- Strobe A (vend, 10) starts; strobe B (vend, 01) arrives while busy; strobe C (vend, 00) arrives while busy -> A completes and then B runs from the buffer; C is dropped and overrun=1; coins_total=3.
- TIMEOUT=8, coin_ack never asserted -> jam=1 on the 8th COIN cycle, coin_req low, coins_left=2. Then clr_err -> IDLE, jam=0, coins_left=0.
- coin_ack pulsed during GAP and IDLE -> ignored; coins_total unchanged.
